// File: rtl/fsm_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_bus_master_pkg
// Brief    : Shared state encoding for the bus-master FSM and its checkers.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_bus_master_pkg;

    localparam int unsigned c_ST_W = 3;

    typedef logic [c_ST_W-1:0] state_t;

    localparam state_t c_ST_IDLE = 3'd0;
    localparam state_t c_ST_REQ  = 3'd1;
    localparam state_t c_ST_XFER = 3'd2;
    localparam state_t c_ST_FIN  = 3'd3;
    localparam state_t c_ST_HOLD = 3'd4;

    function automatic logic st_is_busy(input state_t st);
        return st != c_ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_bm_cnt.sv
`default_nettype none
// ============================================================================
// Module   : fsm_bm_cnt
// Brief    : Loadable up-counter with clear, enable and terminal-count compare.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_bm_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tc_val,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_en) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign o_q  = r_q;
    assign o_tc = (r_q == i_tc_val);

endmodule
`default_nettype wire

// File: rtl/fsm_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : fsm_bus_master
// Brief    : Requesting side of the req/gnt/done/dly bus protocol.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_bus_master
    import fsm_bus_master_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int TO_W   = 4,
    parameter int REQ_TO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    input  logic             tgt_rdy,
    input  logic             tgt_busy,
    output logic             req,
    output logic             done,
    output logic             dly,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             busy,
    output logic             err
);

    localparam bit             c_TO_EN   = (REQ_TO != 0);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'((REQ_TO == 0) ? 0 : REQ_TO - 1);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic             r_hold;
    logic             r_err;
    logic             w_err_set;
    logic             w_accept;
    logic             w_beat;
    logic             w_beat_tc;
    logic             w_to_en;
    logic             w_to_tc;
    logic [TO_W-1:0]  w_to_q;

    assign w_accept = (r_state == c_ST_IDLE) && start && (len != '0);
    assign w_beat   = (r_state == c_ST_XFER) && gnt && tgt_rdy;
    // Saturate so a disabled timeout cannot alias back to zero on long waits.
    assign w_to_en  = (r_state == c_ST_REQ) && !gnt && (w_to_q != '1);

    fsm_bm_cnt #(
        .WIDTH (LEN_W)
    ) u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (1'b0),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_en       (w_beat),
        .i_tc_val   (r_len - LEN_W'(1)),
        .o_q        (beat_idx),
        .o_tc       (w_beat_tc)
    );

    fsm_bm_cnt #(
        .WIDTH (TO_W)
    ) u_to_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_accept),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_to_en),
        .i_tc_val   (c_TO_LAST),
        .o_q        (w_to_q),
        .o_tc       (w_to_tc)
    );

    always_comb begin
        w_next    = 'x;
        w_err_set = 1'b0;
        case (r_state)
            c_ST_IDLE: w_next = w_accept ? c_ST_REQ : c_ST_IDLE;
            c_ST_REQ: begin
                if (gnt) begin
                    w_next = c_ST_XFER;
                end else if (c_TO_EN && w_to_tc) begin
                    w_next    = c_ST_IDLE;
                    w_err_set = 1'b1;
                end else begin
                    w_next = c_ST_REQ;
                end
            end
            c_ST_XFER: begin
                if (!gnt) begin
                    w_next    = c_ST_IDLE;
                    w_err_set = 1'b1;
                end else if (tgt_rdy && w_beat_tc) begin
                    w_next = c_ST_FIN;
                end else begin
                    w_next = c_ST_XFER;
                end
            end
            c_ST_FIN:  w_next = r_hold ? c_ST_HOLD : c_ST_IDLE;
            c_ST_HOLD: w_next = tgt_busy ? c_ST_HOLD : c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_len   <= '0;
            r_hold  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (w_accept) begin
                r_len <= len;
            end
            if (w_beat && w_beat_tc) begin
                r_hold <= tgt_busy;
            end
        end
    end

    assign req        = (r_state == c_ST_REQ) || (r_state == c_ST_XFER);
    assign done       = (r_state == c_ST_FIN);
    assign dly        = ((r_state == c_ST_FIN) && r_hold) || (r_state == c_ST_HOLD);
    assign busy       = st_is_busy(r_state);
    assign err        = r_err;
    assign beat_valid = w_beat;

endmodule
`default_nettype wire
